// File: rtl/corelet_pkg.sv
// Shared types and constants for the corelet sequencer: FSM states, inst bit
// positions and the SFU accumulate latency.
package corelet_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WLD   = 3'd1,
    WKRN  = 3'd2,
    FLUSH = 3'd3,
    XLD   = 3'd4,
    EXEC  = 3'd5,
    DRAIN = 3'd6,
    DONE  = 3'd7
  } corelet_state_e;

  localparam int INST_L0_RD = 4;
  localparam int INST_L0_WR = 3;
  localparam int INST_MODE  = 2;
  localparam int INST_EXEC  = 1;
  localparam int INST_WLOAD = 0;

  localparam int SFU_LAT = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// N-stage {valid, addr} shift register with synchronous active-low reset.
// Used to align L0 writes and psum writes with upstream read latencies.
module ctrl_delay_line #(
  parameter int N  = 1,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  output logic          out_valid,
  output logic [AW-1:0] out_addr
);

  logic [N-1:0]  v_q;
  logic [AW-1:0] a_q [N];

  always_ff @(posedge clk) begin
    if (!reset) begin
      v_q <= '0;
      for (int i = 0; i < N; i++) a_q[i] <= '0;
    end else begin
      v_q[0] <= in_valid;
      a_q[0] <= in_addr;
      for (int i = 1; i < N; i++) begin
        v_q[i] <= v_q[i-1];
        a_q[i] <= a_q[i-1];
      end
    end
  end

  assign out_valid = v_q[N-1];
  assign out_addr  = a_q[N-1];

endmodule

// File: rtl/corelet_ctrl.sv
// Corelet sequencer: per kij loads weights, runs activations and drains the
// OFIFO into psum SRAM. Optional perf counters under CORELET_CTRL_PERF_CNT_EN.
module corelet_ctrl
  import corelet_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int len     = 36,
  parameter int num_kij = 9,
  parameter int xaddr_w = 11,
  parameter int paddr_w = 11,
  parameter int flush   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode_in,
  input  logic               ofifo_valid,
  output logic [4:0]         inst,
  output logic               xmem_cen,
  output logic [xaddr_w-1:0] xmem_addr,
  output logic               pmem_cen,
  output logic [paddr_w-1:0] pmem_raddr,
  output logic               pmem_wen,
  output logic [paddr_w-1:0] pmem_waddr,
  output logic               ofifo_rd,
  output logic               sfu_en,
  output logic               busy,
  output logic               done,
  output corelet_state_e     state_dbg
`ifdef CORELET_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]        cyc_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int CNT_W = $clog2(max_int(max_int(row, col), max_int(flush, len))) + 1;
  localparam int PW    = $clog2(len) + 1;
  localparam int KW    = $clog2(num_kij) + 1;

  localparam logic [CNT_W-1:0] COL_LAST   = CNT_W'(col - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(flush - 1);
  localparam logic [CNT_W-1:0] LEN_LAST   = CNT_W'(len - 1);
  localparam logic [PW-1:0]    P_END      = PW'(len);
  localparam logic [PW-1:0]    P_LAST     = PW'(len - 1);
  localparam logic [KW-1:0]    KIJ_LAST   = KW'(num_kij - 1);

  corelet_state_e     state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [KW-1:0]      kij_q;
  logic               mode_q;
  logic [xaddr_w-1:0] wbase_q;
  logic [PW-1:0]      p_q, w_q;

  logic               xrd, l0_wr_q, unused_l0_addr;
  logic               acc, pop, wr_fire, last_wr;
  logic               wr1_v, wr3_v;
  logic [paddr_w-1:0] wr1_a, wr3_a;

  assign xrd     = (state_q == WLD) || (state_q == XLD);
  assign acc     = (kij_q != '0);
  assign pop     = (state_q == DRAIN) && ofifo_valid && (p_q != P_END);
  assign wr_fire = (state_q == DRAIN) && (acc ? wr3_v : wr1_v);
  assign last_wr = wr_fire && (w_q == P_LAST);

  // Input SRAM has one cycle of read latency, so l0_wr trails the read enable.
  ctrl_delay_line #(.N(1), .AW(1)) u_l0_shadow (
    .clk(clk), .reset(reset), .in_valid(xrd), .in_addr(1'b0),
    .out_valid(l0_wr_q), .out_addr(unused_l0_addr)
  );

  // Direct path writes one cycle after the pop; accumulate path waits for the SFU.
  ctrl_delay_line #(.N(1), .AW(paddr_w)) u_wr_direct (
    .clk(clk), .reset(reset), .in_valid(pop), .in_addr(paddr_w'(p_q)),
    .out_valid(wr1_v), .out_addr(wr1_a)
  );

  ctrl_delay_line #(.N(SFU_LAT), .AW(paddr_w)) u_wr_acc (
    .clk(clk), .reset(reset), .in_valid(pop), .in_addr(paddr_w'(p_q)),
    .out_valid(wr3_v), .out_addr(wr3_a)
  );

  assign pmem_wen   = ~wr_fire;
  assign pmem_waddr = acc ? wr3_a : wr1_a;
  assign state_dbg  = state_q;

  always_comb begin
    state_d    = state_q;
    inst       = '0;
    xmem_cen   = 1'b1;
    xmem_addr  = '0;
    pmem_cen   = 1'b1;
    pmem_raddr = '0;
    ofifo_rd   = 1'b0;
    sfu_en     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = WLD;
      WLD: begin
        busy            = 1'b1;
        xmem_cen        = 1'b0;
        xmem_addr       = wbase_q + xaddr_w'(cnt_q);
        inst[INST_MODE] = mode_q;
        if (cnt_q == COL_LAST) state_d = WKRN;
      end
      WKRN: begin
        busy             = 1'b1;
        inst[INST_L0_RD] = 1'b1;
        inst[INST_WLOAD] = 1'b1;
        inst[INST_MODE]  = mode_q;
        if (cnt_q == COL_LAST) state_d = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (cnt_q == FLUSH_LAST) state_d = XLD;
      end
      XLD: begin
        busy            = 1'b1;
        xmem_cen        = 1'b0;
        xmem_addr       = xaddr_w'(cnt_q);
        inst[INST_MODE] = mode_q;
        if (cnt_q == LEN_LAST) state_d = EXEC;
      end
      EXEC: begin
        busy             = 1'b1;
        inst[INST_L0_RD] = 1'b1;
        inst[INST_EXEC]  = 1'b1;
        inst[INST_MODE]  = mode_q;
        if (cnt_q == LEN_LAST) state_d = DRAIN;
      end
      DRAIN: begin
        busy            = 1'b1;
        inst[INST_MODE] = mode_q;
        sfu_en          = acc;
        ofifo_rd        = pop;
        if (acc && pop) begin
          pmem_cen   = 1'b0;
          pmem_raddr = paddr_w'(p_q);
        end
        if (last_wr) state_d = (kij_q == KIJ_LAST) ? DONE : WLD;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    inst[INST_L0_WR] = l0_wr_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      kij_q   <= '0;
      mode_q  <= 1'b0;
      wbase_q <= '0;
      p_q     <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      // Phase counter restarts on every state change.
      if ((state_d == state_q) &&
          (state_q inside {WLD, WKRN, FLUSH, XLD, EXEC}))
        cnt_q <= cnt_q + 1'b1;
      else
        cnt_q <= '0;
      if (state_q == IDLE && start) begin
        mode_q  <= mode_in;
        kij_q   <= '0;
        wbase_q <= xaddr_w'(len);
      end
      if (pop) p_q <= p_q + 1'b1;
      if (wr_fire) w_q <= w_q + 1'b1;
      if (last_wr) begin
        p_q     <= '0;
        w_q     <= '0;
        kij_q   <= kij_q + 1'b1;
        wbase_q <= wbase_q + xaddr_w'(col);
      end
    end
  end

`ifdef CORELET_CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset || (state_q == IDLE && start)) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (busy) cyc_cnt <= cyc_cnt + 1'b1;
      if (state_q == DRAIN && !ofifo_valid) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed bench for corelet_ctrl: two-kij run (direct + accumulate drain),
// start-while-busy, a second run, and reset in the middle of EXEC.
module tb_corelet_ctrl;
  import corelet_pkg::*;

  logic           clk = 1'b0;
  logic           reset, start, mode_in, ofifo_valid;
  logic [4:0]     inst;
  logic           xmem_cen, pmem_cen, pmem_wen, ofifo_rd, sfu_en, busy, done;
  logic [10:0]    xmem_addr, pmem_raddr, pmem_waddr;
  corelet_state_e state_dbg;
`ifdef CORELET_CTRL_PERF_CNT_EN
  logic [31:0]    cyc_cnt, stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  corelet_ctrl #(
    .row(8), .col(8), .len(4), .num_kij(2),
    .xaddr_w(11), .paddr_w(11), .flush(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode_in(mode_in),
    .ofifo_valid(ofifo_valid), .inst(inst), .xmem_cen(xmem_cen),
    .xmem_addr(xmem_addr), .pmem_cen(pmem_cen), .pmem_raddr(pmem_raddr),
    .pmem_wen(pmem_wen), .pmem_waddr(pmem_waddr), .ofifo_rd(ofifo_rd),
    .sfu_en(sfu_en), .busy(busy), .done(done), .state_dbg(state_dbg)
`ifdef CORELET_CTRL_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_state"}, state_dbg, IDLE);
    chk({tag, "_inst"}, inst, 0);
    chk({tag, "_xcen"}, xmem_cen, 1);
    chk({tag, "_pcen"}, pmem_cen, 1);
    chk({tag, "_pwen"}, pmem_wen, 1);
    chk({tag, "_ofrd"}, ofifo_rd, 0);
    chk({tag, "_sfu"}, sfu_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Driver + checker for WLD, WKRN, FLUSH, XLD and exec_n cycles of EXEC.
  task automatic load_phase(input int kij, input logic m, input int exec_n, input bit poke);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("wld_state", state_dbg, WLD);
      chk("wld_cen", xmem_cen, 0);
      chk("wld_addr", xmem_addr, 4 + kij * 8 + i);
      chk("wld_inst", inst, {1'b0, (i > 0), m, 1'b0, 1'b0});
      chk("wld_busy", busy, 1);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("wkrn_state", state_dbg, WKRN);
      chk("wkrn_cen", xmem_cen, 1);
      chk("wkrn_inst", inst, {1'b1, (i == 0), m, 1'b0, 1'b1});
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      if (poke && i == 3) begin
        start   = 1'b1;
        mode_in = ~m;
      end
      #1;
      chk("flush_state", state_dbg, FLUSH);
      chk("flush_inst", inst, 0);
      tick();
      start = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("xld_state", state_dbg, XLD);
      chk("xld_cen", xmem_cen, 0);
      chk("xld_addr", xmem_addr, i);
      chk("xld_inst", inst, {1'b0, (i > 0), m, 1'b0, 1'b0});
      tick();
    end
    for (int i = 0; i < exec_n; i++) begin
      #1;
      chk("exec_state", state_dbg, EXEC);
      chk("exec_inst", inst, {1'b1, (i == 0), m, 1'b1, 1'b0});
      chk("exec_sfu", sfu_en, 0);
      tick();
    end
  endtask

  // Scoreboard for the drain: each expected pop queues its write address and due cycle.
  task automatic drain_phase(input int kij, input bit toggle);
    logic [10:0] exp_q[$];
    int          due_q[$];
    int          pops = 0;
    int          writes = 0;
    int          lat = (kij != 0) ? 3 : 1;
    logic        exp_rd;
    for (int c = 0; c < 40 && writes < 4; c++) begin
      ofifo_valid = toggle ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      #1;
      chk("drain_state", state_dbg, DRAIN);
      chk("drain_sfu", sfu_en, (kij != 0));
      exp_rd = ofifo_valid && (pops < 4);
      chk("drain_ofrd", ofifo_rd, exp_rd);
      if (exp_rd && kij != 0) begin
        chk("drain_pcen", pmem_cen, 0);
        chk("drain_raddr", pmem_raddr, pops);
      end else begin
        chk("drain_pcen_off", pmem_cen, 1);
      end
      if (exp_rd) begin
        exp_q.push_back(11'(pops));
        due_q.push_back(c + lat);
        pops++;
      end
      if (due_q.size() > 0 && due_q[0] == c) begin
        chk("drain_wen", pmem_wen, 0);
        chk("drain_waddr", pmem_waddr, exp_q.pop_front());
        void'(due_q.pop_front());
        writes++;
      end else begin
        chk("drain_wen_off", pmem_wen, 1);
      end
      tick();
    end
    chk("drain_writes", writes, 4);
    ofifo_valid = 1'b0;
  endtask

  initial begin
    reset       = 1'b0;
    start       = 1'b0;
    mode_in     = 1'b0;
    ofifo_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk_idle_outputs("rst");
    tick();

    // Run 1: mode 1, start re-pulsed with mode 0 during FLUSH must be ignored.
    start   = 1'b1;
    mode_in = 1'b1;
    tick();
    start   = 1'b0;
    mode_in = 1'b0;
    load_phase(0, 1'b1, 4, 1'b1);
    drain_phase(0, 1'b0);
    load_phase(1, 1'b1, 4, 1'b0);
    drain_phase(1, 1'b1);
    #1;
    chk("done_state", state_dbg, DONE);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    tick();
    #1;
    chk("post_done_state", state_dbg, IDLE);
    chk("post_done_pulse", done, 0);
`ifdef CORELET_CTRL_PERF_CNT_EN
    chk("perf_cyc", cyc_cnt, 96);
    chk("perf_stall", stall_cnt, 6);
`endif
    tick();
    tick();
    #1;
    chk("idle_hold", state_dbg, IDLE);
`ifdef CORELET_CTRL_PERF_CNT_EN
    chk("perf_cyc_hold", cyc_cnt, 96);
`endif
    tick();

    // Run 2: mode 0, reset asserted mid-EXEC.
    start   = 1'b1;
    mode_in = 1'b0;
    tick();
    start = 1'b0;
`ifdef CORELET_CTRL_PERF_CNT_EN
    #1;
    chk("perf_cyc_clr", cyc_cnt, 0);
    chk("perf_stall_clr", stall_cnt, 0);
    tick();
    load_phase_after_first: begin end
`endif
`ifdef CORELET_CTRL_PERF_CNT_EN
    // One WLD cycle already consumed above; skip straight to the remaining checks.
    for (int i = 1; i < 8; i++) tick();
    for (int i = 0; i < 8 + 16 + 4 + 2; i++) tick();
    #1;
    chk("run2_exec_state", state_dbg, EXEC);
    chk("run2_exec_inst", inst, {1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    #1;
`else
    load_phase(0, 1'b0, 2, 1'b0);
`endif
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk_idle_outputs("rst_exec");
    tick();
    #1;
    chk("rst_exec_stay", state_dbg, IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
